xdma_cfg_deframer: RTL
======================

# xdma_cfg_deframer

Receive-side reassembler for multi-frame inter-cluster XDMA configuration messages. It consumes a stream of wide beats arriving from a remote cluster (the FromRemoteCfg path). Frame 0 carries the header: type, total frame count, DMA id, reader/writer addresses and first payload slice. Frames 1..N-1 carry sequence-tagged payload continuations. It checks sequencing, concatenates payload into one buffered configuration record, and presents it on a valid/ready output. Data width, address width, id width, frame-count width and maximum frame count are parametrised.

## Interface
- DataWidth, 512, wide beat width in bits
- AddrWidth, 48, reader/writer address width
- DMAIdWidth, 4, DMA id width
- FrameLenWidth, 4, width of frame-length / frame-index field; requires MaxFrames <= 2**FrameLenWidth - 1
- MaxFrames, 4, maximum frames per message, >= 1
- Derived: FirstPayW = DataWidth-1-FrameLenWidth-DMAIdWidth-2*AddrWidth (407 at defaults); ContPayW = DataWidth-1-FrameLenWidth (507); PayW = FirstPayW+(MaxFrames-1)*ContPayW

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&ready
- in_data_i  in  DataWidth  beat
- out_valid_o  out  1  assembled record valid
- out_ready_i  in  1  downstream accepts record
- out_dma_type_o  out  1  0 read, 1 write
- out_dma_id_o  out  DMAIdWidth  DMA id
- out_reader_addr_o  out  AddrWidth  reader address
- out_writer_addr_o  out  AddrWidth  writer address
- out_frame_length_o  out  FrameLenWidth  total frames received
- out_payload_o  out  PayW  frame-0 payload in LSBs, frame k payload at [FirstPayW+(k-1)*ContPayW +: ContPayW]; unused slots zero
- err_valid_o  out  1  one-cycle error pulse
- err_code_o  out  2  1 zero length, 2 length > MaxFrames, 3 sequence/type mismatch; 0 when no error

## Operation
- Frame 0 fields, LSB first: [0] dma_type, [FrameLenWidth:1] frame_length, then dma_id, reader_addr, writer_addr, remaining bits = payload.
- Continuation: [0] dma_type (must equal header), [FrameLenWidth:1] frame index k, rest = payload.
- States: IDLE, COLLECT, DRAIN, OUTPUT.
- IDLE, beat accepted:
  - len==0 -> err 1, stay IDLE.
  - len>MaxFrames -> err 2, drain counter=len-1; DRAIN if counter>0, else IDLE.
  - len==1 -> latch header, OUTPUT.
  - otherwise -> latch header, clear payload buffer, next_idx=1, COLLECT.
- COLLECT, beat accepted:
  - dma_type!=header type or index!=next_idx -> err 3, discard partial record, IDLE. Offending beat is consumed.
  - else store payload slot next_idx; if next_idx==len-1 -> OUTPUT, else next_idx++.
- DRAIN: accept beats without checks, decrement counter; IDLE at 0; no output.
- OUTPUT: out_valid_o=1, outputs stable; on out_ready_i -> IDLE.
- in_ready_o = 1 in IDLE/COLLECT/DRAIN, 0 in OUTPUT (single record buffer).
- Counter/index arithmetic is FrameLenWidth bits; no wrap possible under the MaxFrames constraint.

## Timing
- Reset values: in_ready_o 0 during reset cycle then 1 (IDLE), out_valid_o 0, all out_* data 0, err_valid_o 0, err_code_o 0, state IDLE, buffers cleared.
- in_ready_o is registered-state-derived; no combinational path from in_valid_i.
- Latency: last frame accepted cycle N -> out_valid_o high cycle N+1.
- Throughput: one beat/cycle while collecting; one-cycle-minimum OUTPUT gap between records.
- err_valid_o/err_code_o asserted the cycle after the offending beat is accepted, exactly one cycle.
- Output held while out_valid_o & !out_ready_i; data must not change.
- Reset mid-message: partial record, drain counter and pending output discarded; no error pulse.

## Test plan
- 1-frame msg: type=1, len=1, id=3, rd=0x1000, wr=0x2000 -> out_valid next cycle with those fields; payload slots 1..3 zero; in_ready_o 0 until accepted.
- 4-frame msg, indices 1,2,3 back-to-back, out_ready_i held low 5 cycles -> out_valid at N+1, fields stable 5 cycles, payload slots match beats, then IDLE.
- Header len=0 -> err_code 1 pulse, no output, next valid msg assembled normally.
- Header len=6 (MaxFrames=4) + 5 more beats -> err_code 2 once, all 6 beats consumed, no output, following 2-frame msg correct.
- 3-frame msg with second continuation index 3 (expected 2) -> err_code 3; mismatched type on a continuation -> err_code 3; both discard, no output.
- rst_i asserted one cycle after frame 1 of a 4-frame msg -> all outputs reset values; a fresh 2-frame msg completes correctly.

Source files
------------

// File: rtl/xdma_cfg_deframer.sv
// Reassembles multi-frame XDMA configuration messages from wide beats into one
// buffered record presented on a valid/ready output, with sequence checking.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a header frame
// COLLECT | header latched, accepting continuation frames in order
// DRAIN   | oversize message rejected, swallowing its remaining beats
// OUTPUT  | record complete, held until downstream takes it
module xdma_cfg_deframer #(
  parameter int DataWidth     = 512,
  parameter int AddrWidth     = 48,
  parameter int DMAIdWidth    = 4,
  parameter int FrameLenWidth = 4,
  parameter int MaxFrames     = 4,
  localparam int FirstPayW    = DataWidth - 1 - FrameLenWidth - DMAIdWidth - 2 * AddrWidth,
  localparam int ContPayW     = DataWidth - 1 - FrameLenWidth,
  localparam int PayW         = FirstPayW + (MaxFrames - 1) * ContPayW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DataWidth-1:0]     in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_dma_type_o,
  output logic [DMAIdWidth-1:0]    out_dma_id_o,
  output logic [AddrWidth-1:0]     out_reader_addr_o,
  output logic [AddrWidth-1:0]     out_writer_addr_o,
  output logic [FrameLenWidth-1:0] out_frame_length_o,
  output logic [PayW-1:0]          out_payload_o,
  output logic                     err_valid_o,
  output logic [1:0]               err_code_o
);

  localparam int IdLsb   = 1 + FrameLenWidth;
  localparam int RdLsb   = IdLsb + DMAIdWidth;
  localparam int WrLsb   = RdLsb + AddrWidth;
  localparam int PayLsb  = WrLsb + AddrWidth;
  localparam int ContLsb = 1 + FrameLenWidth;
  localparam logic [FrameLenWidth-1:0] MaxLen = FrameLenWidth'(MaxFrames);
  localparam logic [FrameLenWidth-1:0] One    = FrameLenWidth'(1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_OUTPUT} state_t;

  state_t                   state_q, state_d;
  logic                     type_q;
  logic [FrameLenWidth-1:0] len_q;
  logic [DMAIdWidth-1:0]    id_q;
  logic [AddrWidth-1:0]     rd_q, wr_q;
  logic [PayW-1:0]          pay_q;
  logic [FrameLenWidth-1:0] next_idx_q;
  logic [FrameLenWidth-1:0] drain_cnt_q;
  logic                     err_valid_q;
  logic [1:0]               err_code_q;

  logic                     beat_type;
  logic [FrameLenWidth-1:0] beat_len;
  logic                     fire;
  logic [1:0]               err_d;
  logic                     latch_hdr, store_cont, idx_inc, drain_load, drain_dec;

  assign beat_type  = in_data_i[0];
  assign beat_len   = in_data_i[FrameLenWidth:1];
  // Ready depends only on state (and reset), never on in_valid_i.
  assign in_ready_o = ~rst_i & (state_q != S_OUTPUT);
  assign fire       = in_valid_i & in_ready_o;

  always_comb begin
    state_d    = state_q;
    err_d      = 2'd0;
    latch_hdr  = 1'b0;
    store_cont = 1'b0;
    idx_inc    = 1'b0;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (beat_len == '0) begin
            err_d = 2'd1;
          end else if (beat_len > MaxLen) begin
            err_d      = 2'd2;
            drain_load = 1'b1;
            if (beat_len != One) state_d = S_DRAIN;
          end else begin
            latch_hdr = 1'b1;
            state_d   = (beat_len == One) ? S_OUTPUT : S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (fire) begin
          if (beat_type != type_q || beat_len != next_idx_q) begin
            err_d   = 2'd3;
            state_d = S_IDLE;
          end else begin
            store_cont = 1'b1;
            if (next_idx_q == len_q - One) state_d = S_OUTPUT;
            else                           idx_inc = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (fire) begin
          drain_dec = 1'b1;
          if (drain_cnt_q == One) state_d = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      type_q      <= 1'b0;
      len_q       <= '0;
      id_q        <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      pay_q       <= '0;
      next_idx_q  <= '0;
      drain_cnt_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      err_valid_q <= (err_d != 2'd0);
      err_code_q  <= err_d;
      if (latch_hdr) begin
        type_q     <= beat_type;
        len_q      <= beat_len;
        id_q       <= in_data_i[IdLsb +: DMAIdWidth];
        rd_q       <= in_data_i[RdLsb +: AddrWidth];
        wr_q       <= in_data_i[WrLsb +: AddrWidth];
        // Upper slots cleared so short records read back zero there.
        pay_q      <= PayW'(in_data_i[PayLsb +: FirstPayW]);
        next_idx_q <= One;
      end
      if (store_cont) begin
        for (int k = 1; k < MaxFrames; k++) begin
          if (next_idx_q == FrameLenWidth'(k))
            pay_q[FirstPayW + (k - 1) * ContPayW +: ContPayW] <= in_data_i[ContLsb +: ContPayW];
        end
      end
      if (idx_inc) next_idx_q <= next_idx_q + One;
      if (drain_load)     drain_cnt_q <= beat_len - One;
      else if (drain_dec) drain_cnt_q <= drain_cnt_q - One;
    end
  end

  assign out_valid_o        = (state_q == S_OUTPUT);
  assign out_dma_type_o     = type_q;
  assign out_dma_id_o       = id_q;
  assign out_reader_addr_o  = rd_q;
  assign out_writer_addr_o  = wr_q;
  assign out_frame_length_o = len_q;
  assign out_payload_o      = pay_q;
  assign err_valid_o        = err_valid_q;
  assign err_code_o         = err_code_q;

endmodule
